// File: rtl/controle_alarme.sv
// Anti-theft alarm sequencer: arm/trigger/siren state machine plus the countdown fed by Parametros_Tempo.
// Build option: define SIREN_PULSE_EN for a siren that toggles every second while sounding.
module controle_alarme #(
   parameter int TIMER_W = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               one_hz_enable,
   input  logic               ignition,
   input  logic               door_driver,
   input  logic               door_pass,
   input  logic               reprogram,
   input  logic [TIMER_W-1:0] value,
   output logic [1:0]         interval,
   output logic               siren,
   output logic               status,
   output logic [2:0]         state_dbg
);

   typedef enum logic [2:0] {
      ARMED      = 3'd0,
      TRIGGER    = 3'd1,
      SOUND      = 3'd2,
      DISARMED   = 3'd3,
      WAIT_OPEN  = 3'd4,
      WAIT_CLOSE = 3'd5,
      ARM_DELAY  = 3'd6
   } state_e;

   localparam logic [1:0] T_ARM_DELAY       = 2'b00;
   localparam logic [1:0] T_DRIVER_DELAY    = 2'b01;
   localparam logic [1:0] T_PASSENGER_DELAY = 2'b10;
   localparam logic [1:0] T_ALARM_ON        = 2'b11;

`ifdef SIREN_PULSE_EN
   localparam bit SIREN_PULSED = 1'b1;
`else
   localparam bit SIREN_PULSED = 1'b0;
`endif

   state_e             state_q, state_d;
   logic [1:0]         interval_q, interval_d;
   logic [TIMER_W-1:0] counter_q, counter_d;
   logic               load_pend_q, load_pend_d;
   logic               siren_q, siren_d;
   logic               status_q, status_d;

   logic               expired;
   logic               any_door;
   logic               start_timer;
   logic               hold_timer;
   logic [1:0]         timer_sel;

   assign expired  = (counter_q == '0) && !load_pend_q;
   assign any_door = door_driver | door_pass;

   // Next state; priority is reprogram > ignition > doors > expiry.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d     = state_q;
      start_timer = 1'b0;
      hold_timer  = 1'b0;
      timer_sel   = interval_q;

      case (state_q)
         ARMED: begin
            if (ignition) begin
               state_d = DISARMED;
            end else if (door_driver) begin
               state_d     = TRIGGER;
               start_timer = 1'b1;
               timer_sel   = T_DRIVER_DELAY;
            end else if (door_pass) begin
               state_d     = TRIGGER;
               start_timer = 1'b1;
               timer_sel   = T_PASSENGER_DELAY;
            end
         end
         TRIGGER: begin
            if (ignition) begin
               state_d = DISARMED;
            end else if (expired) begin
               state_d     = SOUND;
               start_timer = 1'b1;
               timer_sel   = T_ALARM_ON;
            end
         end
         SOUND: begin
            if (ignition) begin
               state_d = DISARMED;
            end else if (any_door) begin
               hold_timer = 1'b1;
            end else if (expired) begin
               state_d = ARMED;
            end
         end
         DISARMED: begin
            if (!ignition) state_d = WAIT_OPEN;
         end
         WAIT_OPEN: begin
            if (ignition)         state_d = DISARMED;
            else if (door_driver) state_d = WAIT_CLOSE;
         end
         WAIT_CLOSE: begin
            if (ignition) begin
               state_d = DISARMED;
            end else if (!door_driver) begin
               state_d     = ARM_DELAY;
               start_timer = 1'b1;
               timer_sel   = T_ARM_DELAY;
            end
         end
         ARM_DELAY: begin
            if (ignition) begin
               state_d = DISARMED;
            end else if (any_door) begin
               start_timer = 1'b1;
               timer_sel   = T_ARM_DELAY;
            end else if (expired) begin
               state_d = ARMED;
            end
         end
         default: state_d = ARMED;
      endcase

      if (reprogram) begin
         state_d     = ARMED;
         start_timer = 1'b0;
         hold_timer  = 1'b0;
      end
   end

   // A pending load means value belongs to the freshly written interval; the counter copies it one cycle later.
   always_comb begin
      interval_d  = interval_q;
      load_pend_d = load_pend_q;
      counter_d   = counter_q;

      if (hold_timer) begin
         load_pend_d = 1'b1;
      end else if (load_pend_q) begin
         counter_d   = value;
         load_pend_d = 1'b0;
      end else if (one_hz_enable && (counter_q != '0)) begin
         counter_d = counter_q - TIMER_W'(1);
      end

      if (start_timer) begin
         interval_d  = timer_sel;
         load_pend_d = 1'b1;
      end

      if (reprogram) begin
         interval_d  = T_ARM_DELAY;
         load_pend_d = 1'b0;
      end
   end

   // Outputs are computed from the next state so they change on the same edge as state_dbg.
   always_comb begin
      siren_d  = 1'b0;
      status_d = 1'b0;

      case (state_d)
         ARMED: begin
            status_d = (state_q == ARMED) ? (status_q ^ one_hz_enable) : 1'b0;
         end
         TRIGGER: begin
            status_d = 1'b1;
         end
         SOUND: begin
            status_d = 1'b1;
            if (state_q != SOUND)  siren_d = 1'b1;
            else if (SIREN_PULSED) siren_d = siren_q ^ one_hz_enable;
            else                   siren_d = 1'b1;
         end
         default: begin
            siren_d  = 1'b0;
            status_d = 1'b0;
         end
      endcase

      if (reprogram) begin
         siren_d  = 1'b0;
         status_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ARMED;
         interval_q  <= T_ARM_DELAY;
         counter_q   <= '0;
         load_pend_q <= 1'b0;
         siren_q     <= 1'b0;
         status_q    <= 1'b0;
      end else begin
         // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         interval_q  <= interval_d;
         counter_q   <= counter_d;
         load_pend_q <= load_pend_d;
         siren_q     <= siren_d;
         status_q    <= status_d;
      end
   end

   assign interval  = interval_q;
   assign siren     = siren_q;
   assign status    = status_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_controle_alarme.sv
// Self-checking bench for controle_alarme; durations come from a behavioural Parametros_Tempo model.
// Timed states are measured in one_hz_enable ticks seen after the counter load edge.
module tb_controle_alarme;

   localparam int TIMER_W = 5;

   localparam logic [2:0] S_ARMED      = 3'd0;
   localparam logic [2:0] S_TRIGGER    = 3'd1;
   localparam logic [2:0] S_SOUND      = 3'd2;
   localparam logic [2:0] S_DISARMED   = 3'd3;
   localparam logic [2:0] S_WAIT_OPEN  = 3'd4;
   localparam logic [2:0] S_WAIT_CLOSE = 3'd5;
   localparam logic [2:0] S_ARM_DELAY  = 3'd6;

`ifdef SIREN_PULSE_EN
   localparam bit PULSED = 1'b1;
`else
   localparam bit PULSED = 1'b0;
`endif

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               one_hz_enable = 1'b0;
   logic               ignition = 1'b0;
   logic               door_driver = 1'b0;
   logic               door_pass = 1'b0;
   logic               reprogram = 1'b0;
   logic [TIMER_W-1:0] value;
   logic [1:0]         interval;
   logic               siren;
   logic               status;
   logic [2:0]         state_dbg;

   // Parametros_Tempo at reset defaults: arm delay, driver delay, passenger delay, alarm on.
   int param [4] = '{6, 8, 15, 10};
   assign value = TIMER_W'(param[interval]);

   int tests = 0;
   int fails = 0;
   int tick_edges = 0;
   bit last_tick = 1'b0;
   bit siren_model = 1'b0;
   logic [2:0] prev_dbg = 3'd0;

   controle_alarme #(.TIMER_W(TIMER_W)) dut (
      .clock         (clock),
      .reset         (reset),
      .one_hz_enable (one_hz_enable),
      .ignition      (ignition),
      .door_driver   (door_driver),
      .door_pass     (door_pass),
      .reprogram     (reprogram),
      .value         (value),
      .interval      (interval),
      .siren         (siren),
      .status        (status),
      .state_dbg     (state_dbg)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      tick_edges <= tick_edges + (one_hz_enable ? 1 : 0);
      last_tick  <= one_hz_enable;
   end

   initial begin : tick_gen
      int ph;
      ph = 0;
      forever begin
         @(posedge clock);
         #2;
         ph = (ph + 1) % 4;
         one_hz_enable = (ph == 0);
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Advance one clock; also tracks the expected siren level while sounding.
   task automatic step();
      @(posedge clock);
      #1;
      if (state_dbg === S_SOUND) begin
         if (prev_dbg !== S_SOUND) siren_model = 1'b1;
         else if (PULSED && last_tick) siren_model = ~siren_model;
      end
      prev_dbg = state_dbg;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic do_reprogram(input int sel, input int val);
      param[sel] = val;
      reprogram = 1'b1;
      step();
      reprogram = 1'b0;
   endtask

   // Call with the counter load edge as the next edge; returns ticks spent before reaching target.
   task automatic wait_state(input logic [2:0] target, output int ticks, output bit reached,
                             output int siren_errs);
      int base;
      int prev;
      reached = 1'b0;
      ticks = 0;
      siren_errs = 0;
      step();
      base = tick_edges;
      for (int c = 0; c < 400; c++) begin
         prev = tick_edges;
         step();
         if (state_dbg === target) begin
            reached = 1'b1;
            ticks = prev - base;
            break;
         end
         if (siren !== ((state_dbg === S_SOUND) ? siren_model : 1'b0)) siren_errs++;
      end
   endtask

   task automatic test_reset();
      int base;
      #1 reset = 1'b1;
      #1;
      tests++; if (state_dbg !== S_ARMED) begin fails++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_ARMED); end
      tests++; if (interval !== 2'b00) begin fails++; $display("FAIL reset_interval: got %0d expected 0", interval); end
      tests++; if (siren !== 1'b0) begin fails++; $display("FAIL reset_siren: got %0b expected 0", siren); end
      tests++; if (status !== 1'b0) begin fails++; $display("FAIL reset_status: got %0b expected 0", status); end
      idle(2);
      reset = 1'b0;
      base = tick_edges;
      idle(13);
      tests++; if (status !== 1'((tick_edges - base) % 2)) begin fails++; $display("FAIL armed_blink: got %0b expected %0d", status, (tick_edges - base) % 2); end
      tests++; if (state_dbg !== S_ARMED) begin fails++; $display("FAIL armed_idle: got %0d expected %0d", state_dbg, S_ARMED); end
   endtask

   task automatic test_driver_trigger();
      int t, se;
      bit ok;
      idle($urandom_range(0, 3));
      door_driver = 1'b1; step(); door_driver = 1'b0;
      tests++; if (state_dbg !== S_TRIGGER) begin fails++; $display("FAIL drv_state: got %0d expected %0d", state_dbg, S_TRIGGER); end
      tests++; if (interval !== 2'b01) begin fails++; $display("FAIL drv_interval: got %0d expected 1", interval); end
      tests++; if (status !== 1'b1) begin fails++; $display("FAIL drv_status: got %0b expected 1", status); end
      wait_state(S_SOUND, t, ok, se);
      tests++; if (!ok) begin fails++; $display("FAIL drv_reach_sound: got timeout expected state %0d", S_SOUND); end
      tests++; if (t != param[1]) begin fails++; $display("FAIL drv_delay_ticks: got %0d expected %0d", t, param[1]); end
      tests++; if (siren !== 1'b1 || interval !== 2'b11) begin fails++; $display("FAIL sound_entry: got siren %0b interval %0d expected 1 and 3", siren, interval); end
   endtask

   // Entered right after the SOUND entry edge.
   task automatic test_sound_hold();
      int base, k, errs, t, se;
      bit ok;
      step();
      base = tick_edges;
      k = $urandom_range(1, param[3] - 1);
      for (int c = 0; c < 400 && (tick_edges - base) < k; c++) step();
      tests++; if (state_dbg !== S_SOUND) begin fails++; $display("FAIL hold_pre: got %0d expected %0d", state_dbg, S_SOUND); end
      door_pass = 1'b1;
      errs = 0;
      repeat ($urandom_range(8, 14)) begin
         step();
         if (state_dbg !== S_SOUND || siren !== siren_model) errs++;
      end
      tests++; if (errs != 0) begin fails++; $display("FAIL hold_open: got %0d bad cycles expected 0", errs); end
      door_pass = 1'b0;
      wait_state(S_ARMED, t, ok, se);
      tests++; if (!ok) begin fails++; $display("FAIL hold_reach_armed: got timeout expected state %0d", S_ARMED); end
      tests++; if (t != param[3]) begin fails++; $display("FAIL hold_restart_ticks: got %0d expected %0d", t, param[3]); end
      tests++; if (se != 0) begin fails++; $display("FAIL sound_siren: got %0d bad cycles expected 0", se); end
      tests++; if (siren !== 1'b0) begin fails++; $display("FAIL armed_siren: got %0b expected 0", siren); end
   endtask

   task automatic test_disarm_arm();
      int t, se, base;
      bit ok;
      for (int run = 0; run < 2; run++) begin
         ignition = 1'b1; step();
         tests++; if (state_dbg !== S_DISARMED || status !== 1'b0) begin fails++; $display("FAIL disarm: got state %0d status %0b expected %0d and 0", state_dbg, status, S_DISARMED); end
         ignition = 1'b0; step();
         tests++; if (state_dbg !== S_WAIT_OPEN) begin fails++; $display("FAIL wait_open: got %0d expected %0d", state_dbg, S_WAIT_OPEN); end
         door_driver = 1'b1; step();
         tests++; if (state_dbg !== S_WAIT_CLOSE) begin fails++; $display("FAIL wait_close: got %0d expected %0d", state_dbg, S_WAIT_CLOSE); end
         idle($urandom_range(0, 3));
         door_driver = 1'b0; step();
         tests++; if (state_dbg !== S_ARM_DELAY || interval !== 2'b00) begin fails++; $display("FAIL arm_delay_entry: got state %0d interval %0d expected %0d and 0", state_dbg, interval, S_ARM_DELAY); end
         if (run == 1) begin
            step();
            base = tick_edges;
            for (int c = 0; c < 400 && (tick_edges - base) < 2; c++) step();
            door_pass = 1'b1; step(); door_pass = 1'b0;
            tests++; if (state_dbg !== S_ARM_DELAY || interval !== 2'b00) begin fails++; $display("FAIL arm_reopen: got state %0d interval %0d expected %0d and 0", state_dbg, interval, S_ARM_DELAY); end
         end
         wait_state(S_ARMED, t, ok, se);
         tests++; if (!ok || t != param[0]) begin fails++; $display("FAIL arm_delay_ticks: got %0d (reached %0b) expected %0d", t, ok, param[0]); end
      end
   endtask

   task automatic test_both_doors();
      door_driver = 1'b1; door_pass = 1'b1; step();
      door_driver = 1'b0; door_pass = 1'b0;
      tests++; if (state_dbg !== S_TRIGGER || interval !== 2'b01) begin fails++; $display("FAIL both_doors: got state %0d interval %0d expected %0d and 1", state_dbg, interval, S_TRIGGER); end
      do_reprogram(1, param[1]);
      tests++; if (state_dbg !== S_ARMED) begin fails++; $display("FAIL both_doors_rearm: got %0d expected %0d", state_dbg, S_ARMED); end
   endtask

   task automatic test_reprogram();
      int t, se;
      bit ok;
      door_pass = 1'b1; step(); door_pass = 1'b0;
      tests++; if (state_dbg !== S_TRIGGER || interval !== 2'b10) begin fails++; $display("FAIL pass_trigger: got state %0d interval %0d expected %0d and 2", state_dbg, interval, S_TRIGGER); end
      idle($urandom_range(1, 6));
      do_reprogram(1, 5);
      tests++; if (state_dbg !== S_ARMED || siren !== 1'b0 || status !== 1'b0 || interval !== 2'b00) begin
         fails++; $display("FAIL reprogram: got state %0d siren %0b status %0b interval %0d expected 0 0 0 0", state_dbg, siren, status, interval);
      end
      door_driver = 1'b1; step(); door_driver = 1'b0;
      wait_state(S_SOUND, t, ok, se);
      tests++; if (!ok || t != 5) begin fails++; $display("FAIL reprog_delay: got %0d (reached %0b) expected 5", t, ok); end
      wait_state(S_ARMED, t, ok, se);
      tests++; if (!ok || t != param[3] || se != 0) begin fails++; $display("FAIL reprog_alarm: got %0d ticks %0d siren errs expected %0d and 0", t, se, param[3]); end
   endtask

   task automatic test_ignition_vs_expired();
      int base;
      do_reprogram(2, $urandom_range(1, 4));
      door_pass = 1'b1; step(); door_pass = 1'b0;
      step();
      base = tick_edges;
      for (int c = 0; c < 400 && (tick_edges - base) < param[2]; c++) step();
      tests++; if (state_dbg !== S_TRIGGER) begin fails++; $display("FAIL ign_exp_pre: got %0d expected %0d", state_dbg, S_TRIGGER); end
      ignition = 1'b1; step(); ignition = 1'b0;
      tests++; if (state_dbg !== S_DISARMED || siren !== 1'b0 || status !== 1'b0) begin
         fails++; $display("FAIL ign_vs_expired: got state %0d siren %0b status %0b expected %0d 0 0", state_dbg, siren, status, S_DISARMED);
      end
      step();
      do_reprogram(0, param[0]);
   endtask

   task automatic test_back_to_back();
      int d, a, choice, sel, t, se;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         d = (i == 0) ? 0 : $urandom_range(0, 6);
         a = (i == 1) ? 0 : $urandom_range(0, 5);
         choice = $urandom_range(0, 2);
         sel = (choice == 1) ? 2 : 1;
         do_reprogram(sel, d);
         do_reprogram(3, a);
         idle($urandom_range(0, 3));
         door_driver = (choice != 1);
         door_pass = (choice != 0);
         step();
         door_driver = 1'b0; door_pass = 1'b0;
         tests++; if (interval !== 2'(sel)) begin fails++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d", i, interval, sel); end
         wait_state(S_SOUND, t, ok, se);
         tests++; if (!ok || t != d) begin fails++; $display("FAIL b2b_trigger[%0d]: got %0d (reached %0b) expected %0d", i, t, ok, d); end
         wait_state(S_ARMED, t, ok, se);
         tests++; if (!ok || t != a || se != 0) begin fails++; $display("FAIL b2b_sound[%0d]: got %0d ticks %0d siren errs expected %0d and 0", i, t, se, a); end
      end
   endtask

   task automatic test_async_reset();
      int t, se;
      bit ok;
      do_reprogram(3, 12);
      door_driver = 1'b1; step(); door_driver = 1'b0;
      wait_state(S_SOUND, t, ok, se);
      idle($urandom_range(2, 6));
      tests++; if (state_dbg !== S_SOUND || siren !== siren_model) begin fails++; $display("FAIL pre_reset_sound: got state %0d siren %0b expected %0d and %0b", state_dbg, siren, S_SOUND, siren_model); end
      #3 reset = 1'b1;
      #1;
      tests++; if (siren !== 1'b0 || state_dbg !== S_ARMED || interval !== 2'b00 || status !== 1'b0) begin
         fails++; $display("FAIL async_reset: got siren %0b state %0d interval %0d status %0b expected all 0", siren, state_dbg, interval, status);
      end
      #1 reset = 1'b0;
      step();
      tests++; if (state_dbg !== S_ARMED || siren !== 1'b0) begin fails++; $display("FAIL post_reset: got state %0d siren %0b expected 0 and 0", state_dbg, siren); end
   endtask

   initial begin
      test_reset();
      test_driver_trigger();
      test_sound_hold();
      test_disarm_arm();
      test_both_doors();
      test_reprogram();
      test_ignition_vs_expired();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
